// File: rtl/pe_sad_acc.sv
// Motion-estimation PE: NUM_CB current-block pixel banks, one reference pixel,
// and a two-stage pipelined SAD accumulator over ACC_LEN absolute differences.
module pe_sad_acc #(
  parameter  int PIXEL_W  = 8,
  parameter  int NUM_CB   = 4,
  parameter  int ACC_LEN  = 64,
  localparam int CB_SEL_W = $clog2(NUM_CB),
  localparam int PAIR_W   = $clog2(NUM_CB) - 1,
  localparam int ACC_W    = PIXEL_W + $clog2(ACC_LEN)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PIXEL_W-1:0]  in_curr1,
  input  logic [PIXEL_W-1:0]  in_curr2,
  input  logic                in_curr_enable,
  input  logic [PAIR_W-1:0]   cb_pair_sel,
  input  logic [PIXEL_W-1:0]  down_ref_adjacent_1,
  input  logic [PIXEL_W-1:0]  down_ref_adjacent_8,
  input  logic                change_ref,
  input  logic                ref_input_control,
  input  logic [CB_SEL_W-1:0] abs_control,
  input  logic                acc_en,
  input  logic                acc_clear,
  output logic [PIXEL_W-1:0]  abs_out,
  output logic [PIXEL_W-1:0]  next_pix1,
  output logic [PIXEL_W-1:0]  next_pix2,
  output logic [PIXEL_W-1:0]  ref_pix,
  output logic [ACC_W-1:0]    sad_out,
  output logic                sad_valid,
  output logic                sad_busy
);

  localparam int CNT_W = $clog2(ACC_LEN);

  // |a - b| on unsigned pixels; one extra bit keeps the difference exact.
  function automatic logic [PIXEL_W-1:0] abs_diff(input logic [PIXEL_W-1:0] a,
                                                  input logic [PIXEL_W-1:0] b);
    logic signed [PIXEL_W:0] d;
    logic signed [PIXEL_W:0] n;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    n = -d;
    return d[PIXEL_W] ? n[PIXEL_W-1:0] : d[PIXEL_W-1:0];
  endfunction

  // ACC_W is sized for ACC_LEN full-scale differences, so the sum never wraps.
  function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0]   acc,
                                               input logic [PIXEL_W-1:0] val);
    return acc + {{(ACC_W-PIXEL_W){1'b0}}, val};
  endfunction

  logic [PIXEL_W-1:0] cb [NUM_CB];
  logic [PIXEL_W-1:0] abs_p1;
  logic               vld_p1;
  logic [ACC_W-1:0]   acc_p2;
  logic [CNT_W-1:0]   cnt_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CB; i++) cb[i] <= '0;
    end else if (in_curr_enable) begin
      for (int i = 0; i < NUM_CB/2; i++) begin
        if (cb_pair_sel == PAIR_W'(i)) begin
          cb[2*i]   <= in_curr1;
          cb[2*i+1] <= in_curr2;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_pix <= '0;
    end else if (change_ref) begin
      ref_pix <= ref_input_control ? down_ref_adjacent_8 : down_ref_adjacent_1;
    end
  end

  assign abs_out   = abs_diff(cb[abs_control], ref_pix);
  assign next_pix1 = cb[{cb_pair_sel, 1'b0}];
  assign next_pix2 = cb[{cb_pair_sel, 1'b1}];

  // Stage 1: register the sampled absolute difference
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      abs_p1 <= '0;
      vld_p1 <= 1'b0;
    end else if (acc_clear) begin
      vld_p1 <= 1'b0;
    end else if (acc_en) begin
      abs_p1 <= abs_out;
      vld_p1 <= 1'b1;
    end else begin
      vld_p1 <= 1'b0;
    end
  end

  // Stage 2: accumulate; the final sample goes straight to sad_out so the
  // next SAD can start on the following sample without an idle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p2    <= '0;
      cnt_p2    <= '0;
      sad_out   <= '0;
      sad_valid <= 1'b0;
    end else if (acc_clear) begin
      acc_p2    <= '0;
      cnt_p2    <= '0;
      sad_valid <= 1'b0;
    end else if (vld_p1) begin
      if (cnt_p2 == CNT_W'(ACC_LEN-1)) begin
        sad_out   <= acc_add(acc_p2, abs_p1);
        sad_valid <= 1'b1;
        acc_p2    <= '0;
        cnt_p2    <= '0;
      end else begin
        acc_p2    <= acc_add(acc_p2, abs_p1);
        cnt_p2    <= cnt_p2 + 1'b1;
        sad_valid <= 1'b0;
      end
    end else begin
      sad_valid <= 1'b0;
    end
  end

  assign sad_busy = vld_p1 | (cnt_p2 != '0);

endmodule

// File: tb/tb_pe_sad_acc.sv
// Self-checking bench for pe_sad_acc: directed scenarios plus random traffic,
// every cycle compared against a queue-based SAD reference model.
module tb_pe_sad_acc;
  localparam int PIXEL_W  = 8;
  localparam int NUM_CB   = 4;
  localparam int ACC_LEN  = 64;
  localparam int CB_SEL_W = 2;
  localparam int PAIR_W   = 1;
  localparam int ACC_W    = 14;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [PIXEL_W-1:0]  in_curr1, in_curr2;
  logic                in_curr_enable;
  logic [PAIR_W-1:0]   cb_pair_sel;
  logic [PIXEL_W-1:0]  down_ref_adjacent_1, down_ref_adjacent_8;
  logic                change_ref, ref_input_control;
  logic [CB_SEL_W-1:0] abs_control;
  logic                acc_en, acc_clear;
  logic [PIXEL_W-1:0]  abs_out, next_pix1, next_pix2, ref_pix;
  logic [ACC_W-1:0]    sad_out;
  logic                sad_valid, sad_busy;

  pe_sad_acc #(.PIXEL_W(PIXEL_W), .NUM_CB(NUM_CB), .ACC_LEN(ACC_LEN)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_curr1(in_curr1), .in_curr2(in_curr2), .in_curr_enable(in_curr_enable),
    .cb_pair_sel(cb_pair_sel),
    .down_ref_adjacent_1(down_ref_adjacent_1), .down_ref_adjacent_8(down_ref_adjacent_8),
    .change_ref(change_ref), .ref_input_control(ref_input_control),
    .abs_control(abs_control), .acc_en(acc_en), .acc_clear(acc_clear),
    .abs_out(abs_out), .next_pix1(next_pix1), .next_pix2(next_pix2), .ref_pix(ref_pix),
    .sad_out(sad_out), .sad_valid(sad_valid), .sad_busy(sad_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: pixel values as ints, committed differences in a queue.
  int m_cb [NUM_CB];
  int m_ref;
  int m_q [$];
  bit m_inflight;
  int m_infl_val;
  int m_sad;
  bit m_valid;
  int pulses;
  int pulse_sads [$];

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CB; i++) m_cb[i] = 0;
    m_ref = 0;
    m_q.delete();
    m_inflight = 0;
    m_infl_val = 0;
    m_sad = 0;
    m_valid = 0;
  endtask

  task automatic model_edge();
    int d;
    if (!rst_n) begin
      model_reset();
      return;
    end
    d = absd(m_cb[abs_control], m_ref);
    m_valid = 0;
    if (acc_clear) begin
      m_q.delete();
      m_inflight = 0;
    end else begin
      if (m_inflight) begin
        m_q.push_back(m_infl_val);
        if (m_q.size() == ACC_LEN) begin
          m_sad = m_q.sum();
          m_valid = 1;
          m_q.delete();
        end
      end
      m_inflight = acc_en;
      m_infl_val = d;
    end
    if (in_curr_enable) begin
      m_cb[2*cb_pair_sel]   = in_curr1;
      m_cb[2*cb_pair_sel+1] = in_curr2;
    end
    if (change_ref) m_ref = ref_input_control ? down_ref_adjacent_8 : down_ref_adjacent_1;
  endtask

  task automatic check_all();
    chk("abs_out",   abs_out,   absd(m_cb[abs_control], m_ref));
    chk("next_pix1", next_pix1, m_cb[2*cb_pair_sel]);
    chk("next_pix2", next_pix2, m_cb[2*cb_pair_sel+1]);
    chk("ref_pix",   ref_pix,   m_ref);
    chk("sad_out",   sad_out,   m_sad);
    chk("sad_valid", sad_valid, m_valid);
    chk("sad_busy",  sad_busy,  (m_inflight || m_q.size() != 0) ? 1 : 0);
    if (sad_valid === 1'b1) begin
      pulses++;
      pulse_sads.push_back(int'(sad_out));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic write_pair(input int p, input int a, input int b);
    cb_pair_sel = PAIR_W'(p);
    in_curr1 = PIXEL_W'(a);
    in_curr2 = PIXEL_W'(b);
    in_curr_enable = 1;
    tick();
    in_curr_enable = 0;
  endtask

  task automatic load_ref(input bit sel, input int v);
    ref_input_control = sel;
    if (sel) down_ref_adjacent_8 = PIXEL_W'(v);
    else     down_ref_adjacent_1 = PIXEL_W'(v);
    change_ref = 1;
    tick();
    change_ref = 0;
  endtask

  task automatic samples(input int n, input bit gaps);
    int sent;
    sent = 0;
    while (sent < n) begin
      acc_en = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (acc_en) sent++;
      tick();
    end
    acc_en = 0;
  endtask

  int p0;

  initial begin
    rst_n = 1;
    in_curr1 = 8'd11; in_curr2 = 8'd22; in_curr_enable = 1; cb_pair_sel = 0;
    down_ref_adjacent_1 = 8'd33; down_ref_adjacent_8 = 8'd44;
    change_ref = 1; ref_input_control = 0; abs_control = 0;
    acc_en = 1; acc_clear = 0;
    pulses = 0;
    model_reset();
    #2 rst_n = 0;

    // Reset with enables active
    tick(); tick(); tick();
    chk("rst_abs", abs_out, 0);
    chk("rst_busy", sad_busy, 0);
    rst_n = 1;
    in_curr_enable = 0; change_ref = 0; acc_en = 0;
    tick(); tick();
    chk("post_rst_sad", sad_out, 0);

    // Bank load and abs
    write_pair(0, 10, 20);
    write_pair(1, 30, 40);
    cb_pair_sel = 0; #1;
    chk("np_sel0", {next_pix1, next_pix2}, {8'd10, 8'd20});
    cb_pair_sel = 1; #1;
    chk("np_sel1", {next_pix1, next_pix2}, {8'd30, 8'd40});
    load_ref(0, 25);
    abs_control = 0; #1; chk("abs0", abs_out, 15);
    abs_control = 1; #1; chk("abs1", abs_out, 5);
    abs_control = 2; #1; chk("abs2", abs_out, 5);
    abs_control = 3; #1; chk("abs3", abs_out, 15);

    // Reference select
    down_ref_adjacent_1 = 7;
    load_ref(1, 99);
    chk("ref_adj8", ref_pix, 99);
    down_ref_adjacent_1 = 1; down_ref_adjacent_8 = 2;
    tick(); tick();
    chk("ref_hold", ref_pix, 99);
    load_ref(0, 7);
    chk("ref_adj1", ref_pix, 7);

    // Full SAD, then full-scale without wrap
    write_pair(0, 200, 0);
    load_ref(0, 50);
    abs_control = 0;
    p0 = pulses;
    samples(ACC_LEN, 0);
    chk("lat_early", sad_valid, 0);
    tick();
    chk("lat_valid", sad_valid, 1);
    chk("sad_9600", sad_out, 9600);
    tick();
    chk("pulse_once", pulses - p0, 1);
    write_pair(0, 255, 0);
    load_ref(0, 0);
    samples(ACC_LEN, 0);
    tick(); tick();
    chk("sad_16320", sad_out, 16320);

    // Stalls then back-to-back SADs
    write_pair(0, 53, 51);
    load_ref(0, 50);
    abs_control = 0;
    p0 = pulses;
    pulse_sads.delete();
    samples(ACC_LEN, 1);
    abs_control = 1;
    samples(ACC_LEN, 1);
    tick(); tick(); tick();
    chk("b2b_pulses", pulses - p0, 2);
    if (pulse_sads.size() == 2) begin
      chk("b2b_first", pulse_sads[0], 192);
      chk("b2b_second", pulse_sads[1], 64);
    end

    // Abort mid-run, then abort on the final sample
    write_pair(1, 52, 50);
    abs_control = 0;
    p0 = pulses;
    samples(30, 0);
    acc_clear = 1; tick(); acc_clear = 0;
    chk("clr_busy", sad_busy, 0);
    abs_control = 2;
    samples(ACC_LEN, 0);
    tick(); tick();
    chk("abort_pulses", pulses - p0, 1);
    chk("sad_128", sad_out, 128);
    p0 = pulses;
    samples(ACC_LEN, 0);
    acc_clear = 1; tick(); acc_clear = 0;
    chk("clr_final_valid", sad_valid, 0);
    tick(); tick();
    chk("clr_final_pulses", pulses - p0, 0);
    chk("clr_final_hold", sad_out, 128);

    // Random traffic, with one mid-run reset
    for (int i = 0; i < 600; i++) begin
      in_curr1 = PIXEL_W'($urandom); in_curr2 = PIXEL_W'($urandom);
      in_curr_enable = ($urandom_range(0, 7) == 0);
      cb_pair_sel = PAIR_W'($urandom);
      down_ref_adjacent_1 = PIXEL_W'($urandom); down_ref_adjacent_8 = PIXEL_W'($urandom);
      change_ref = ($urandom_range(0, 7) == 0);
      ref_input_control = 1'($urandom);
      abs_control = CB_SEL_W'($urandom);
      acc_en = ($urandom_range(0, 3) != 0);
      acc_clear = ($urandom_range(0, 99) == 0);
      if (i == 300) begin
        rst_n = 0;
        model_reset();
        #1;
        check_all();
      end else if (i == 302) begin
        rst_n = 1;
      end
      tick();
    end
    acc_en = 0; acc_clear = 0; in_curr_enable = 0; change_ref = 0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
